// File: rtl/mips_pkg.sv
// Shared pipeline constants: forwarding select codes and register-specifier sizing.
package mips_pkg;

    localparam int unsigned REG_ADDR_BITS = 5;
    localparam int unsigned SEL_BITS      = 2;

    localparam int unsigned FWD_SEL_RF    = 0;
    localparam int unsigned FWD_SEL_EXMEM = 1;
    localparam int unsigned FWD_SEL_MEMWB = 2;

    localparam int unsigned REG_ZERO      = 0;

endpackage

// File: rtl/fwd_stage_reg.sv
// Shadow pipeline-stage register: async active-low reset, hold, and bubble insertion.
module fwd_stage_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold dominates bubble so a frozen pipeline never loses its occupant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!hold) begin
            q <= bubble ? '0 : d;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding select and load-use stall generation from shadow EX/MEM/WB state.
// Optional saturating stall/forward counters when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_unit #(
    parameter int unsigned REG_ADDR_BITS = mips_pkg::REG_ADDR_BITS,
    parameter int unsigned SEL_BITS      = mips_pkg::SEL_BITS
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic [REG_ADDR_BITS-1:0] i_id_rs,
    input  logic [REG_ADDR_BITS-1:0] i_id_rt,
    input  logic [REG_ADDR_BITS-1:0] i_id_dst,
    input  logic                     i_id_reg_write,
    input  logic                     i_id_mem_to_reg,
    output logic [SEL_BITS-1:0]      o_sel_a,
    output logic [SEL_BITS-1:0]      o_sel_b,
    output logic                     o_hazard_stall
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [15:0]              o_stall_cnt,
    output logic [15:0]              o_fwd_cnt
`endif
);

    import mips_pkg::FWD_SEL_RF;
    import mips_pkg::FWD_SEL_EXMEM;
    import mips_pkg::FWD_SEL_MEMWB;
    import mips_pkg::REG_ZERO;

    localparam int unsigned EX_W  = 3 * REG_ADDR_BITS + 2;
    localparam int unsigned MEM_W = REG_ADDR_BITS + 2;
    localparam int unsigned WB_W  = REG_ADDR_BITS + 1;

    localparam logic [REG_ADDR_BITS-1:0] ZERO_REG = REG_ADDR_BITS'(REG_ZERO);
    localparam logic [SEL_BITS-1:0]      SEL_RF   = SEL_BITS'(FWD_SEL_RF);
    localparam logic [SEL_BITS-1:0]      SEL_EXM  = SEL_BITS'(FWD_SEL_EXMEM);
    localparam logic [SEL_BITS-1:0]      SEL_MWB  = SEL_BITS'(FWD_SEL_MEMWB);

    logic [EX_W-1:0]          ex_d;
    logic [EX_W-1:0]          ex_q;
    logic [MEM_W-1:0]         mem_d;
    logic [MEM_W-1:0]         mem_q;
    logic [WB_W-1:0]          wb_d;
    logic [WB_W-1:0]          wb_q;

    logic [REG_ADDR_BITS-1:0] ex_rs;
    logic [REG_ADDR_BITS-1:0] ex_rt;
    logic [REG_ADDR_BITS-1:0] ex_dst;
    logic                     ex_we;
    logic                     ex_load;
    logic [REG_ADDR_BITS-1:0] mem_dst;
    logic                     mem_we;
    logic                     mem_load_unused;
    logic [REG_ADDR_BITS-1:0] wb_dst;
    logic                     wb_we;

    logic                     ex_bubble;
    logic                     mem_fwd_ok;
    logic                     wb_fwd_ok;

    assign {ex_rs, ex_rt, ex_dst, ex_we, ex_load} = ex_q;
    // MEM.load is tracked for visibility; the load-use bubble means it never gates forwarding.
    assign {mem_dst, mem_we, mem_load_unused}     = mem_q;
    assign {wb_dst, wb_we}                        = wb_q;

    assign ex_d  = {i_id_rs, i_id_rt, i_id_dst, i_id_reg_write, i_id_mem_to_reg};
    assign mem_d = {ex_dst, ex_we, ex_load};
    assign wb_d  = {mem_dst, mem_we};

    // A flush coinciding with a load-use hazard still yields a single bubble.
    assign ex_bubble = i_flush | o_hazard_stall;

    fwd_stage_reg #(.WIDTH(EX_W)) u_ex (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .hold   (i_stall),
        .bubble (ex_bubble),
        .d      (ex_d),
        .q      (ex_q)
    );

    fwd_stage_reg #(.WIDTH(MEM_W)) u_mem (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .hold   (i_stall),
        .bubble (1'b0),
        .d      (mem_d),
        .q      (mem_q)
    );

    fwd_stage_reg #(.WIDTH(WB_W)) u_wb (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .hold   (i_stall),
        .bubble (1'b0),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign mem_fwd_ok = mem_we & (mem_dst != ZERO_REG);
    assign wb_fwd_ok  = wb_we & (wb_dst != ZERO_REG);

    // MEM is the most recent writer, so it takes priority over WB.
    always_comb begin
        o_sel_a = SEL_RF;
        o_sel_b = SEL_RF;
        if (mem_fwd_ok && (mem_dst == ex_rs)) begin
            o_sel_a = SEL_EXM;
        end else if (wb_fwd_ok && (wb_dst == ex_rs)) begin
            o_sel_a = SEL_MWB;
        end
        if (mem_fwd_ok && (mem_dst == ex_rt)) begin
            o_sel_b = SEL_EXM;
        end else if (wb_fwd_ok && (wb_dst == ex_rt)) begin
            o_sel_b = SEL_MWB;
        end
    end

    assign o_hazard_stall = ex_load & ex_we & (ex_dst != ZERO_REG) &
                            ((ex_dst == i_id_rs) | (ex_dst == i_id_rt));

`ifdef FWD_HAZARD_STATS_EN
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    logic fwd_any;
    assign fwd_any = (o_sel_a != SEL_RF) | (o_sel_b != SEL_RF);

    // Saturating event counters; frozen cycles are not counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
            o_fwd_cnt   <= '0;
        end else if (!i_stall) begin
            if (o_hazard_stall && (o_stall_cnt != STAT_MAX)) begin
                o_stall_cnt <= o_stall_cnt + 16'd1;
            end
            if (fwd_any && (o_fwd_cnt != STAT_MAX)) begin
                o_fwd_cnt <= o_fwd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: expected selects/stall queued per step and checked mid-cycle.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       flush;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_dst;
    logic       id_we;
    logic       id_ld;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       hz;
`ifdef FWD_HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] fwd_cnt;
`endif

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       hz;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    fwd_hazard_unit dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_id_rs         (id_rs),
        .i_id_rt         (id_rt),
        .i_id_dst        (id_dst),
        .i_id_reg_write  (id_we),
        .i_id_mem_to_reg (id_ld),
        .o_sel_a         (sel_a),
        .o_sel_b         (sel_b),
        .o_hazard_stall  (hz)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .o_stall_cnt     (stall_cnt),
        .o_fwd_cnt       (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [1:0] ea, input logic [1:0] eb, input logic eh);
        exp_t e;
        e.a  = ea;
        e.b  = eb;
        e.hz = eh;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        n_tests++;
        assert (sel_a === e.a) else begin
            n_fail++;
            $error("FAIL %s sel_a got=%0d want=%0d", tag, sel_a, e.a);
        end
        n_tests++;
        assert (sel_b === e.b) else begin
            n_fail++;
            $error("FAIL %s sel_b got=%0d want=%0d", tag, sel_b, e.b);
        end
        n_tests++;
        assert (hz === e.hz) else begin
            n_fail++;
            $error("FAIL %s hazard_stall got=%0d want=%0d", tag, hz, e.hz);
        end
    endtask

    // One pipeline cycle: drive ID/control after the falling edge, check before the rising edge.
    task automatic step(input string tag,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                        input logic we, input logic ld, input logic st, input logic fl,
                        input logic [1:0] ea, input logic [1:0] eb, input logic eh);
        @(negedge clk);
        id_rs  = rs;
        id_rt  = rt;
        id_dst = dst;
        id_we  = we;
        id_ld  = ld;
        stall  = st;
        flush  = fl;
        push_exp(ea, eb, eh);
        #1;
        check_out(tag);
    endtask

    task automatic check_shadows_zero(input string tag);
        n_tests++;
        assert (dut.ex_q === '0) else begin
            n_fail++;
            $error("FAIL %s ex_shadow got=%0h want=0", tag, dut.ex_q);
        end
        n_tests++;
        assert (dut.mem_q === '0) else begin
            n_fail++;
            $error("FAIL %s mem_shadow got=%0h want=0", tag, dut.mem_q);
        end
        n_tests++;
        assert (dut.wb_q === '0) else begin
            n_fail++;
            $error("FAIL %s wb_shadow got=%0h want=0", tag, dut.wb_q);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        id_rs  = '0;
        id_rt  = '0;
        id_dst = '0;
        id_we  = 1'b0;
        id_ld  = 1'b0;
        #2;
        push_exp(2'd0, 2'd0, 1'b0);
        check_out("reset");
        check_shadows_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // add $3 -> sub $5,$3,$4 : EX/MEM forward on A
        step("c0_add",   5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c1_sub",   5'd3, 5'd4, 5'd5, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c2_fwdA",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd1, 2'd0, 0);
        step("c3",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c4",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        // add $3, nop, or $6,$1,$3 : MEM/WB forward on B
        step("c5_add",   5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c6",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c7_or",    5'd1, 5'd3, 5'd6, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c8_fwdB",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd2, 0);

        // same with $0 as destination: register zero never forwards
        step("c9_add0",  5'd1, 5'd2, 5'd0, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c10",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c11_or",   5'd1, 5'd0, 5'd6, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c12_r0",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        // double hit: MEM wins over WB
        step("c13_add",  5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c14_addi", 5'd3, 5'd0, 5'd3, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c15_and",  5'd3, 5'd3, 5'd7, 1, 0, 0, 0, 2'd1, 2'd0, 0);
        step("c16_dbl",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd1, 2'd1, 0);
        step("c17",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c18",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        // lw $2 -> add $4,$2,$1 : one bubble then WB forward
        step("c19_lw",   5'd1, 5'd0, 5'd2, 1, 1, 0, 0, 2'd0, 2'd0, 0);
        step("c20_hz",   5'd2, 5'd1, 5'd4, 1, 0, 0, 0, 2'd0, 2'd0, 1);
        step("c21_bub",  5'd2, 5'd1, 5'd4, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c22_wbA",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd2, 2'd0, 0);
        step("c23",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        // freeze for three cycles while forwarding
        step("c24_add",  5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c25_sub",  5'd3, 5'd4, 5'd5, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c26_frz",  5'd9, 5'd9, 5'd9, 1, 0, 1, 0, 2'd1, 2'd0, 0);
        step("c27_frz",  5'd9, 5'd9, 5'd9, 1, 0, 1, 0, 2'd1, 2'd0, 0);
        step("c28_frz",  5'd9, 5'd9, 5'd9, 1, 0, 1, 0, 2'd1, 2'd0, 0);
        step("c29_held", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd1, 2'd0, 0);
        step("c30",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        // freeze dominates the load-use bubble
        step("c31_lw",   5'd1, 5'd0, 5'd2, 1, 1, 0, 0, 2'd0, 2'd0, 0);
        step("c32_hzfz", 5'd2, 5'd1, 5'd4, 1, 0, 1, 0, 2'd0, 2'd0, 1);
        step("c33_hz",   5'd2, 5'd1, 5'd4, 1, 0, 0, 0, 2'd0, 2'd0, 1);
        step("c34_bub",  5'd2, 5'd1, 5'd4, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c35_wbA",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd2, 2'd0, 0);

        // flush replaces the entering instruction with a bubble
        step("c36_add",  5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c37_fl",   5'd3, 5'd3, 5'd5, 1, 0, 0, 1, 2'd0, 2'd0, 0);
        step("c38_flb",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c39",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        // flush coincident with hazard
        step("c40_lw",   5'd1, 5'd0, 5'd2, 1, 1, 0, 0, 2'd0, 2'd0, 0);
        step("c41_hzfl", 5'd2, 5'd1, 5'd4, 1, 0, 0, 1, 2'd0, 2'd0, 1);
        step("c42_bub",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        // hazard through rt, then WB forward on B
        step("c43_lw",   5'd1, 5'd0, 5'd6, 1, 1, 0, 0, 2'd0, 2'd0, 0);
        step("c44_hzrt", 5'd1, 5'd6, 5'd7, 1, 0, 0, 0, 2'd0, 2'd0, 1);
        step("c45_bub",  5'd1, 5'd6, 5'd7, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c46_wbB",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd2, 0);

        // load into $0 never stalls
        step("c47_lw0",  5'd1, 5'd0, 5'd0, 1, 1, 0, 0, 2'd0, 2'd0, 0);
        step("c48_nohz", 5'd0, 5'd1, 5'd4, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c49",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        // asynchronous reset mid-run with MEM.we=1 and a live hazard
        step("c50_add",  5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c51_lw",   5'd3, 5'd0, 5'd2, 1, 1, 0, 0, 2'd0, 2'd0, 0);
        step("c52_pre",  5'd2, 5'd3, 5'd4, 1, 0, 0, 0, 2'd1, 2'd0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        push_exp(2'd0, 2'd0, 1'b0);
        check_out("rst_async");
        check_shadows_zero("rst_async");
        id_rs  = '0;
        id_rt  = '0;
        id_dst = '0;
        id_we  = 1'b0;
        id_ld  = 1'b0;
        @(negedge clk);
        check_shadows_zero("rst_held");
        rst_n = 1'b1;
        step("c53",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        step("c54",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Control block directly upstream of the EX-stage operand muxes; drives their 2-bit select inputs (i_en).
- Keeps its own shadow copy of the pipeline destination info for EX, MEM and WB.
- Picks a forwarding source for operands A and B of the instruction in EX.
- Detects load-use hazards and asks the front end to stall for one bubble.

Parameters:
- REG_ADDR_BITS, 5, width of a register specifier.
- SEL_BITS, 2, width of each mux select; equals the operand mux BITS_ENABLES.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_stall  in  1  global freeze from the debug unit; all shadow registers hold.
- i_flush  in  1  branch taken; the instruction entering EX is replaced by a bubble.
- i_id_rs  in  REG_ADDR_BITS  rs of the instruction in ID.
- i_id_rt  in  REG_ADDR_BITS  rt of the instruction in ID.
- i_id_dst  in  REG_ADDR_BITS  destination register of the instruction in ID.
- i_id_reg_write  in  1  ID instruction writes the register file.
- i_id_mem_to_reg  in  1  ID instruction is a load.
- o_sel_a  out  SEL_BITS  select for the EX operand-A mux.
- o_sel_b  out  SEL_BITS  select for the EX operand-B mux.
- o_hazard_stall  out  1  load-use hazard: hold PC and IF/ID.

Behaviour:
- Shadow stages:
  - EX holds {rs, rt, dst, we, load}.
  - MEM holds {dst, we, load}.
  - WB holds {dst, we}.
- Reset (asynchronous, i_rst_n=0): every shadow field is 0.
  - Outputs go to o_sel_a=0, o_sel_b=0, o_hazard_stall=0 immediately, without waiting for a clock edge.
- Each rising edge, with i_stall=0:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields, or a bubble (we=0, load=0, regs=0) when i_flush=1 or o_hazard_stall=1.
- i_stall=1: every shadow register holds, and i_stall dominates i_flush and o_hazard_stall.
- Select codes:
  - 0 = register file.
  - 1 = EX/MEM ALU result.
  - 2 = MEM/WB write-back value.
  - 3 = reserved, never driven.
- o_sel_a and o_sel_b are combinational from the shadow registers, so they are valid in the same cycle the instruction sits in EX (zero latency).
- o_sel_a, in priority order:
  - 1 if MEM.we, MEM.dst!=0 and MEM.dst==EX.rs.
  - else 2 if WB.we, WB.dst!=0 and WB.dst==EX.rs.
  - else 0.
- o_sel_b: same rules using EX.rt.
- MEM always wins over WB when both match (most recent write).
- Register 0 never forwards, even with we=1.
- o_hazard_stall = EX.load & EX.we & (EX.dst!=0) & (EX.dst==i_id_rs | EX.dst==i_id_rt).
  - Combinational.
  - Exactly one bubble is inserted; the next cycle the load is in MEM, and the stall deasserts unless a new hazard exists.
  - After the bubble, the consumer picks up the load data through WB forwarding (sel=2).
- A load sitting in MEM is never forwarded with sel=1; the bubble guarantees that case cannot occur.
- A flush coincident with a hazard inserts one bubble, not two.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- Defined: adds two outputs.
  - o_stall_cnt [15:0]: counts cycles with o_hazard_stall=1 and i_stall=0.
  - o_fwd_cnt [15:0]: counts cycles with any non-zero select and i_stall=0.
  - Both saturate at 0xFFFF.
  - Both clear on reset.
  - Both are readable by the debug unit.
- Undefined: neither port exists and there is no counter logic; forwarding behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - localparams FWD_SEL_RF=0, FWD_SEL_EXMEM=1, FWD_SEL_MEMWB=2.
  - REG_ADDR_BITS.
  - Zero-register constant REG_ZERO=0.
- One sub-module: fwd_stage_reg.
  - Parameterized-width shadow register with asynchronous active-low reset, hold, and bubble inputs.
  - Instantiated three times (EX, MEM, WB).

Test Plan:
- Reset mid-run: assert i_rst_n=0 while MEM.we=1 -> sels go to 0 and stall goes to 0 before the next edge; all shadows are 0.
- add $3 followed by sub $5,$3,$4 -> when sub is in EX, o_sel_a=1 and o_sel_b=0.
- add $3, nop, or $6,$1,$3 -> o_sel_b=2 when or is in EX; same test with $0 as destination -> sel=0.
- Double hit: add $3 then addi $3 then and $7,$3,$3 -> o_sel_a=o_sel_b=1 (MEM priority).
- lw $2 followed by add $4,$2,$1 -> o_hazard_stall=1 for exactly 1 cycle, EX gets a bubble, then o_sel_a=2.
- i_stall=1 for 3 cycles during a forward -> sels and all shadows frozen; i_flush=1 with stall=0 -> EX.we=0 on the next cycle.
